// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle shift-add multiplier for ALU_MUL in EX.
// One multiplier bit is consumed per RUN cycle. The low 32 bits of the
// product go to data_o with a one-cycle valid_o strobe in DONE.
// Optional build macro: MUL_EARLY_TERM_EN. When it is defined, RUN ends as
// soon as the remaining multiplier bits are all zero.
module mul_sequencer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] data_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] mcand, mplier, acc, data_q;
    logic [4:0]  cnt;
    logic [31:0] acc_sum;
    logic [31:0] mplier_shr;
    logic        last_iter;
    logic        accept;

    // Partial-product accumulate and shift for the current iteration
    always_comb begin
        acc_sum    = acc + (mplier[0] ? mcand : 32'd0);
        mplier_shr = mplier >> 1;
`ifdef MUL_EARLY_TERM_EN
        last_iter  = (cnt == 5'd31) || (mplier_shr == 32'd0);
`else
        last_iter  = (cnt == 5'd31);
`endif
        // A flush in IDLE also swallows a coincident start
        accept     = (state == IDLE) && start_i && !flush_i;
    end

    // Next-state logic; flush beats both start and the RUN->DONE exit
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (flush_i) state_nxt = IDLE;
                     else if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // Operand load, iteration, and result capture on entry to DONE
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            data_q <= '0;
        end else begin
            if (accept) begin
                mcand  <= data1_i;
                mplier <= data2_i;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == RUN && !flush_i) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier_shr;
                cnt    <= cnt + 5'd1;
                if (last_iter) data_q <= acc_sum;
            end
        end
    end

    // Outputs depend on registered state only
    always_comb begin
        busy_o  = (state != IDLE);
        valid_o = (state == DONE);
        data_o  = data_q;
    end

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] data1_i = '0;
    logic [31:0] data2_i = '0;
    logic        busy_o, valid_o;
    logic [31:0] data_o;

    int n_checks = 0;
    int n_fail   = 0;

    mul_sequencer dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .flush_i (flush_i),
        .data1_i (data1_i),
        .data2_i (data2_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .data_o  (data_o)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Expected number of RUN cycles for a given multiplier
    function automatic int run_len(input logic [31:0] b);
        int l;
`ifdef MUL_EARLY_TERM_EN
        l = 1;
        for (int i = 0; i < 32; i++) if (b[i]) l = i + 1;
`else
        l = 32;
`endif
        return l;
    endfunction

    // Issue one request and check busy/valid/data on every cycle until idle
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string nm);
        int l;
        l = run_len(b);
        data1_i = a; data2_i = b; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int c = 1; c <= l + 2; c++) begin
            n_checks++;
            if (busy_o !== (c <= l + 1)) begin
                n_fail++;
                $display("FAIL %s busy cyc%0d got %b exp %b", nm, c, busy_o, (c <= l + 1));
            end
            n_checks++;
            if (valid_o !== (c == l + 1)) begin
                n_fail++;
                $display("FAIL %s valid cyc%0d got %b exp %b", nm, c, valid_o, (c == l + 1));
            end
            if (c >= l + 1) begin
                n_checks++;
                if (data_o !== exp) begin
                    n_fail++;
                    $display("FAIL %s data cyc%0d got %h exp %h", nm, c, data_o, exp);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        tick(); tick();
        n_checks++;
        if ({busy_o, valid_o, data_o} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset outs got %b %b %h exp 0 0 0", busy_o, valid_o, data_o);
        end
        rst_i = 1'b1;
        tick();
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset idle busy got %b exp 0", busy_o);
        end
    endtask

    task automatic test_basic();
        run_op(32'd7, 32'd6, 32'd42, "mul_7x6");
        run_op(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, "mul_m3x5");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_m1xm1");
        run_op(32'd100, 32'd3, 32'd300, "mul_100x3");
        run_op(32'd5, 32'd0, 32'd0, "mul_5x0");
    endtask

    task automatic test_back_to_back();
        int l;
        l = run_len(32'd6);
        data1_i = 32'd7; data2_i = 32'd6; start_i = 1'b1;
        tick();
        // start stays high with new operands; must be ignored until idle
        data1_i = 32'd9; data2_i = 32'd9;
        for (int c = 1; c <= l + 1; c++) begin
            n_checks++;
            if (busy_o !== 1'b1 || valid_o !== (c == l + 1)) begin
                n_fail++;
                $display("FAIL b2b first cyc%0d busy %b valid %b exp 1 %b", c, busy_o, valid_o, (c == l + 1));
            end
            tick();
        end
        n_checks++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0 || data_o !== 32'd42) begin
            n_fail++;
            $display("FAIL b2b gap busy %b valid %b data %h exp 0 0 0000002a", busy_o, valid_o, data_o);
        end
        // start is still high here and is taken by run_op's start edge
        run_op(32'd9, 32'd9, 32'd81, "b2b_9x9");
    endtask

    task automatic test_flush();
        data1_i = 32'd5; data2_i = 32'h8000_0001; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0 || data_o !== 32'd81) begin
            n_fail++;
            $display("FAIL flush_run busy %b valid %b data %h exp 0 0 00000051", busy_o, valid_o, data_o);
        end
        run_op(32'd3, 32'd5, 32'd15, "after_flush");
        // flush in IDLE swallows a coincident start
        data1_i = 32'd2; data2_i = 32'd2; start_i = 1'b1; flush_i = 1'b1;
        tick();
        start_i = 1'b0; flush_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || data_o !== 32'd15) begin
            n_fail++;
            $display("FAIL flush_idle busy %b data %h exp 0 0000000f", busy_o, data_o);
        end
    endtask

    task automatic test_reset_mid();
        data1_i = 32'd3; data2_i = 32'h8000_0004; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        rst_i = 1'b0;
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0 || data_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid busy %b valid %b data %h exp 0 0 0", busy_o, valid_o, data_o);
        end
        tick();
        rst_i = 1'b1;
        run_op(32'd3, 32'd4, 32'd12, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
